// File: rtl/loop_nest_sequencer.sv
// Three-level (M, N, K) tile loop sequencer for the GEMM datapath.
// Issues one valid/ready beat per index tuple, K innermost, with per-level last flags.
module loop_nest_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] m_ceil_i,
  input  logic [WIDTH-1:0] n_ceil_i,
  input  logic [WIDTH-1:0] k_ceil_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] m_idx_o,
  output logic [WIDTH-1:0] n_idx_o,
  output logic [WIDTH-1:0] k_idx_o,
  output logic             first_k_o,
  output logic             last_k_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_ceil, n_ceil, k_ceil;
  logic             xfer;
  logic             k_wrap, n_wrap;
  logic [WIDTH-1:0] m_nxt, n_nxt, k_nxt;
  logic             start_zero;

  assign xfer       = valid_o && ready_i;
  assign start_zero = (m_ceil_i == '0) || (n_ceil_i == '0) || (k_ceil_i == '0);

  // Index advance for the beat currently presented; ceilings are latched and non-zero here.
  always_comb begin
    k_wrap = (k_idx_o == k_ceil - WIDTH'(1));
    n_wrap = (n_idx_o == n_ceil - WIDTH'(1));
    k_nxt  = k_wrap ? '0 : k_idx_o + WIDTH'(1);
    n_nxt  = n_idx_o;
    m_nxt  = m_idx_o;
    if (k_wrap) begin
      n_nxt = n_wrap ? '0 : n_idx_o + WIDTH'(1);
      if (n_wrap) begin
        m_nxt = m_idx_o + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      m_ceil    <= '0;
      n_ceil    <= '0;
      k_ceil    <= '0;
      valid_o   <= 1'b0;
      m_idx_o   <= '0;
      n_idx_o   <= '0;
      k_idx_o   <= '0;
      first_k_o <= 1'b0;
      last_k_o  <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else if (abort_i) begin
      state     <= IDLE;
      valid_o   <= 1'b0;
      m_idx_o   <= '0;
      n_idx_o   <= '0;
      k_idx_o   <= '0;
      first_k_o <= 1'b0;
      last_k_o  <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            m_ceil  <= m_ceil_i;
            n_ceil  <= n_ceil_i;
            k_ceil  <= k_ceil_i;
            m_idx_o <= '0;
            n_idx_o <= '0;
            k_idx_o <= '0;
            busy_o  <= 1'b1;
            if (start_zero) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state     <= RUN;
              valid_o   <= 1'b1;
              first_k_o <= 1'b1;
              last_k_o  <= (k_ceil_i == WIDTH'(1));
              last_o    <= (m_ceil_i == WIDTH'(1)) && (n_ceil_i == WIDTH'(1)) &&
                           (k_ceil_i == WIDTH'(1));
            end
          end
        end
        RUN: begin
          // Everything holds unless the presented beat transfers.
          if (xfer) begin
            if (last_o) begin
              state     <= DONE;
              valid_o   <= 1'b0;
              m_idx_o   <= '0;
              n_idx_o   <= '0;
              k_idx_o   <= '0;
              first_k_o <= 1'b0;
              last_k_o  <= 1'b0;
              last_o    <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              m_idx_o   <= m_nxt;
              n_idx_o   <= n_nxt;
              k_idx_o   <= k_nxt;
              first_k_o <= (k_nxt == '0);
              last_k_o  <= (k_nxt == k_ceil - WIDTH'(1));
              last_o    <= (m_nxt == m_ceil - WIDTH'(1)) && (n_nxt == n_ceil - WIDTH'(1)) &&
                           (k_nxt == k_ceil - WIDTH'(1));
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Directed bench for loop_nest_sequencer: expected beats are queued at launch and
// popped as the sequencer transfers them.
module tb_loop_nest_sequencer;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] n;
    logic [7:0] k;
    logic       fk;
    logic       lk;
    logic       l;
  } beat_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       abort_i;
  logic [7:0] m_ceil_i, n_ceil_i, k_ceil_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] m_idx_o, n_idx_o, k_idx_o;
  logic       first_k_o, last_k_o, last_o, busy_o, done_o;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];

  loop_nest_sequencer #(.WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .m_ceil_i(m_ceil_i), .n_ceil_i(n_ceil_i), .k_ceil_i(k_ceil_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .m_idx_o(m_idx_o), .n_idx_o(n_idx_o), .k_idx_o(k_idx_o),
    .first_k_o(first_k_o), .last_k_o(last_k_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur();
    beat_t b;
    b = {m_idx_o, n_idx_o, k_idx_o, first_k_o, last_k_o, last_o};
    return b;
  endfunction

  // Reference order: K innermost, then N, then M.
  task automatic push_nest(input int mc, input int nc, input int kc);
    beat_t b;
    for (int i = 0; i < mc; i++)
      for (int j = 0; j < nc; j++)
        for (int q = 0; q < kc; q++) begin
          b.m  = 8'(i);
          b.n  = 8'(j);
          b.k  = 8'(q);
          b.fk = (q == 0);
          b.lk = (q == kc - 1);
          b.l  = (i == mc - 1) && (j == nc - 1) && (q == kc - 1);
          sb.push_back(b);
        end
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic launch(input int mc, input int nc, input int kc);
    m_ceil_i = 8'(mc);
    n_ceil_i = 8'(nc);
    k_ceil_i = 8'(kc);
    start_i  = 1'b1;
    push_nest(mc, nc, kc);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // cut_kind: 0 none, 1 abort, 2 reset, applied while beat cut_at+1 is presented.
  task automatic consume(input bit rnd, input bit noise, input int cut_at, input int cut_kind);
    beat_t exp, obs, held;
    bit    stall = 1'b0;
    bit    rdy;
    int    cyc = 0;
    int    got = 0;
    held = '0;
    while (sb.size() > 0 && cyc < 4000) begin
      obs = cur();
      if (stall) chk("stall_hold", 32'(obs), 32'(held));
      chk("valid_run", 32'(valid_o), 32'(1));
      chk("done_run", 32'(done_o), 32'(0));
      if (cut_kind != 0 && got == cut_at) begin
        if (cut_kind == 1) abort_i = 1'b1;
        else rst_ni = 1'b0;
        ready_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        abort_i = 1'b0;
        rst_ni  = 1'b1;
        ready_i = 1'b0;
        chk("cut_valid", 32'(valid_o), 32'(0));
        chk("cut_done", 32'(done_o), 32'(0));
        chk("cut_busy", 32'(busy_o), 32'(0));
        chk("cut_idx", 32'({m_idx_o, n_idx_o, k_idx_o}), 32'(0));
        @(negedge clk_i);
        chk("cut_nodone", 32'(done_o), 32'(0));
        chk("cut_idle_valid", 32'(valid_o), 32'(0));
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_i = rdy;
      if (rdy) begin
        exp = sb.pop_front();
        chk("beat", 32'(obs), 32'(exp));
        got++;
      end
      stall = !rdy;
      held  = obs;
      if (noise) begin
        start_i  = (sb.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        m_ceil_i = 8'($urandom);
        n_ceil_i = 8'($urandom);
        k_ceil_i = 8'($urandom);
      end
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    chk("beats_left", 32'(sb.size()), 32'(0));
    chk("done_pulse", 32'(done_o), 32'(1));
    chk("valid_after", 32'(valid_o), 32'(0));
    chk("busy_in_done", 32'(busy_o), 32'(1));
    @(negedge clk_i);
    chk("done_once", 32'(done_o), 32'(0));
    chk("busy_idle", 32'(busy_o), 32'(0));
    chk("valid_idle", 32'(valid_o), 32'(0));
    ready_i = 1'b0;
  endtask

  task automatic zero_nest(input int mc, input int nc, input int kc);
    launch(mc, nc, kc);
    sb.delete();
    chk("zero_done", 32'(done_o), 32'(1));
    chk("zero_valid", 32'(valid_o), 32'(0));
    chk("zero_flags", 32'({first_k_o, last_k_o, last_o}), 32'(0));
    @(negedge clk_i);
    chk("zero_done_once", 32'(done_o), 32'(0));
    chk("zero_busy", 32'(busy_o), 32'(0));
    chk("zero_valid2", 32'(valid_o), 32'(0));
  endtask

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    ready_i  = 1'b0;
    m_ceil_i = '0;
    n_ceil_i = '0;
    k_ceil_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_idx", 32'({m_idx_o, n_idx_o, k_idx_o}), 32'(0));
    chk("rst_flags", 32'({first_k_o, last_k_o, last_o}), 32'(0));
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready_no_effect", 32'(valid_o), 32'(0));
    ready_i = 1'b0;

    launch(2, 3, 4);
    consume(1'b0, 1'b0, 0, 0);
    launch(2, 3, 4);
    consume(1'b1, 1'b0, 0, 0);

    zero_nest(5, 5, 0);
    zero_nest(0, 5, 5);

    launch(1, 1, 1);
    consume(1'b0, 1'b0, 0, 0);

    launch(2, 3, 4);
    consume(1'b1, 1'b0, 6, 1);
    launch(2, 3, 4);
    consume(1'b1, 1'b0, 0, 0);

    launch(2, 3, 4);
    consume(1'b0, 1'b0, 6, 2);
    launch(2, 3, 4);
    consume(1'b0, 1'b0, 0, 0);

    launch(2, 3, 4);
    consume(1'b1, 1'b1, 0, 0);

    launch(1, 2, 255);
    consume(1'b1, 1'b0, 0, 0);
    launch(3, 1, 2);
    consume(1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
